// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared pipeline widths and memory-stage state encoding
package mem_access_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;
    localparam int TMRW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } memState_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - counts consecutive BUSY cycles and flags when LIMIT is reached
module mem_timeout_ctr
    import mem_access_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic run,
    output logic expired
);

    logic [TMRW-1:0] count;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            count <= '0;
        end else if (!run) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // count holds the number of BUSY cycles already completed, so the LIMIT-th cycle fires
    assign expired = run && (count == TMRW'(LIMIT - 1));

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM stage: memory request FSM, pipeline stall and MEM/WB register (option: MEM_TIMEOUT_EN)
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic [XLEN-1:0] ALUOUT,
    input  logic [XLEN-1:0] WDATA,
    input  logic [XLEN-1:0] PC,
    input  logic            DmemREB,
    input  logic            DmemWEB,
    input  logic [REGW-1:0] EXMEMrd,
    input  logic            RegWrite,
    output logic [XLEN-1:0] DmemADDR,
    output logic [XLEN-1:0] DmemWDATA,
    output logic            DmemREQ,
    output logic            DmemWE,
    input  logic [XLEN-1:0] DmemRDATA,
    input  logic            DmemACK,
    output logic            STALL,
    output logic [XLEN-1:0] MEMWBdata,
    output logic [XLEN-1:0] MEMWBPC,
    output logic [REGW-1:0] MEMWBrd,
    output logic            MEMWBwe,
    output logic            MISALIGN,
    output logic            BUSERR
);

    memState_t       state, nextState;
    logic [XLEN-1:0] pcQ;
    logic [REGW-1:0] rdQ;
    logic            weQ;
    logic            memOp, aligned, accept, timedOut;

    assign memOp   = !DmemREB || !DmemWEB;
    assign aligned = (ALUOUT[1:0] == 2'b00);
    assign accept  = (state == IDLE) && memOp && aligned;

`ifdef MEM_TIMEOUT_EN
    mem_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) uTimeout (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .run     (state == BUSY),
        .expired (timedOut)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            BUSERR <= 1'b0;
        end else begin
            BUSERR <= (state == BUSY) && !DmemACK && timedOut;
        end
    end
`else
    assign timedOut = 1'b0;
    assign BUSERR   = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept) nextState = BUSY;
            BUSY:    if (DmemACK || timedOut) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // STALL is gated by RSTN so an asserted reset releases the pipeline even with a load on the inputs
    assign DmemREQ = RSTN && (state == BUSY);
    assign STALL   = RSTN && ((state == BUSY) || accept);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            DmemADDR  <= '0;
            DmemWDATA <= '0;
            DmemWE    <= 1'b0;
            pcQ       <= '0;
            rdQ       <= '0;
            weQ       <= 1'b0;
            MEMWBdata <= '0;
            MEMWBPC   <= '0;
            MEMWBrd   <= '0;
            MEMWBwe   <= 1'b0;
            MISALIGN  <= 1'b0;
        end else begin
            MISALIGN <= 1'b0;
            case (state)
                IDLE: begin
                    if (!memOp || !aligned) begin
                        MEMWBdata <= ALUOUT;
                        MEMWBPC   <= PC;
                        MEMWBrd   <= EXMEMrd;
                        MEMWBwe   <= RegWrite && !memOp;
                        MISALIGN  <= memOp;
                    end else begin
                        DmemADDR  <= ALUOUT;
                        DmemWDATA <= WDATA;
                        DmemWE    <= !DmemWEB;
                        pcQ       <= PC;
                        rdQ       <= EXMEMrd;
                        weQ       <= RegWrite;
                    end
                end
                BUSY: begin
                    if (DmemACK) begin
                        if (!DmemWE) MEMWBdata <= DmemRDATA;
                        MEMWBPC <= pcQ;
                        MEMWBrd <= rdQ;
                        MEMWBwe <= weQ && !DmemWE;
                    end else if (timedOut) begin
                        MEMWBPC <= pcQ;
                        MEMWBrd <= rdQ;
                        MEMWBwe <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - vector table plus directed multi-cycle sequences for mem_access
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] aluout, wdata, pc, dmemRdata;
    logic        dmemReb, dmemWeb, regWrite, dmemAck;
    logic [4:0]  exMemRd;
    logic [31:0] dmemAddr, dmemWdata, memWbData, memWbPc;
    logic        dmemReq, dmemWe, stall, memWbWe, misalign, busErr;
    logic [4:0]  memWbRd;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT_CYCLES(4)) dut (
        .CLK       (clk),
        .RSTN      (rstn),
        .ALUOUT    (aluout),
        .WDATA     (wdata),
        .PC        (pc),
        .DmemREB   (dmemReb),
        .DmemWEB   (dmemWeb),
        .EXMEMrd   (exMemRd),
        .RegWrite  (regWrite),
        .DmemADDR  (dmemAddr),
        .DmemWDATA (dmemWdata),
        .DmemREQ   (dmemReq),
        .DmemWE    (dmemWe),
        .DmemRDATA (dmemRdata),
        .DmemACK   (dmemAck),
        .STALL     (stall),
        .MEMWBdata (memWbData),
        .MEMWBPC   (memWbPc),
        .MEMWBrd   (memWbRd),
        .MEMWBwe   (memWbWe),
        .MISALIGN  (misalign),
        .BUSERR    (busErr)
    );

    typedef struct {
        logic [31:0] aluout;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        regWrite;
        logic        reb;
        logic        web;
        logic        ack;
        logic        checkData;
        logic [31:0] expData;
        logic        expWe;
        logic        expMis;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic nop();
        aluout   = 32'h0;
        wdata    = 32'h0;
        pc       = 32'h0;
        exMemRd  = 5'd0;
        regWrite = 1'b0;
        dmemReb  = 1'b1;
        dmemWeb  = 1'b1;
    endtask

    task automatic runMem(input string name, input logic [31:0] addr, input logic [31:0] wd,
                          input logic reb, input logic web, input logic [4:0] rd, input logic rw,
                          input logic [31:0] pcv, input int ackAfter, input logic [31:0] rdata);
        logic isStore;
        int   stallCycles;
        isStore  = !web;
        aluout   = addr;
        wdata    = wd;
        dmemReb  = reb;
        dmemWeb  = web;
        exMemRd  = rd;
        regWrite = rw;
        pc       = pcv;
        #1;
        check({name, " stall_on_accept"}, stall, 1);
        check({name, " req_on_accept"}, dmemReq, 0);
        stallCycles = 1;
        for (int c = 1; c <= ackAfter; c++) begin
            @(posedge clk); #1;
            if (stall) stallCycles++;
            check({name, " req_busy"}, dmemReq, 1);
            check({name, " addr_busy"}, dmemAddr, addr);
            check({name, " we_busy"}, dmemWe, isStore);
            if (isStore) check({name, " wdata_busy"}, dmemWdata, wd);
            if (c == ackAfter) begin
                dmemAck   = 1'b1;
                dmemRdata = rdata;
            end
        end
        @(posedge clk); #1;
        dmemAck   = 1'b0;
        dmemRdata = 32'h0;
        check({name, " stall_done"}, stall, 0);
        check({name, " req_done"}, dmemReq, 0);
        check({name, " stall_cycles"}, stallCycles, ackAfter + 1);
        check({name, " wb_we"}, memWbWe, isStore ? 1'b0 : rw);
        check({name, " wb_rd"}, memWbRd, rd);
        check({name, " wb_pc"}, memWbPc, pcv);
        if (!isStore) check({name, " wb_data"}, memWbData, rdata);
        nop();
        @(posedge clk); #1;
        check({name, " req_after"}, dmemReq, 0);
        check({name, " stall_after"}, stall, 0);
        if (!isStore) check({name, " wb_data_held"}, memWbData, rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //             aluout        pc           rd    rw    reb   web   ack   chk   expData       we    mis
        vecs[0] = '{32'h0000_1234, 32'h0000_0010, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_1234, 1'b1, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0014, 5'd31, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_0102, 32'h0000_0018, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1};
        vecs[3] = '{32'h8000_0001, 32'h0000_001C, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0001, 1'b1, 1'b0};
        vecs[4] = '{32'h0000_0003, 32'h0000_0020, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1};
        vecs[5] = '{32'h0000_0000, 32'h0000_0024, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

        rstn      = 1'b0;
        dmemAck   = 1'b0;
        dmemRdata = 32'h0;
        nop();
        aluout  = 32'h100;
        dmemReb = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("reset stall", stall, 0);
        check("reset req", dmemReq, 0);
        check("reset addr", dmemAddr, 0);
        check("reset wb_data", memWbData, 0);
        check("reset wb_we", memWbWe, 0);
        check("reset misalign", misalign, 0);
        check("reset buserr", busErr, 0);
        nop();
        rstn = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            aluout   = vecs[i].aluout;
            pc       = vecs[i].pc;
            exMemRd  = vecs[i].rd;
            regWrite = vecs[i].regWrite;
            dmemReb  = vecs[i].reb;
            dmemWeb  = vecs[i].web;
            dmemAck  = vecs[i].ack;
            dmemRdata = 32'hBAD0_BAD0;
            #1;
            check($sformatf("vec%0d stall", i), stall, 0);
            check($sformatf("vec%0d req", i), dmemReq, 0);
            @(posedge clk); #1;
            dmemAck   = 1'b0;
            dmemRdata = 32'h0;
            if (vecs[i].checkData) check($sformatf("vec%0d wb_data", i), memWbData, vecs[i].expData);
            check($sformatf("vec%0d wb_rd", i), memWbRd, vecs[i].rd);
            check($sformatf("vec%0d wb_pc", i), memWbPc, vecs[i].pc);
            check($sformatf("vec%0d wb_we", i), memWbWe, vecs[i].expWe);
            check($sformatf("vec%0d misalign", i), misalign, vecs[i].expMis);
            check($sformatf("vec%0d req_after", i), dmemReq, 0);
        end
        nop();
        @(posedge clk); #1;

        runMem("load100", 32'h100, 32'h0, 1'b0, 1'b1, 5'd5, 1'b1, 32'h200, 3, 32'hDEAD_BEEF);
        runMem("store", 32'h40, 32'hA5A5_A5A5, 1'b0, 1'b0, 5'd9, 1'b1, 32'h204, 2, 32'h0);
        runMem("load_ack1", 32'h44, 32'h0, 1'b0, 1'b1, 5'd10, 1'b1, 32'h208, 1, 32'h0BAD_F00D);

        aluout  = 32'h80;
        dmemReb = 1'b0;
        exMemRd = 5'd6;
        regWrite = 1'b1;
        @(posedge clk); #1;
        check("rst_busy1 req", dmemReq, 1);
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        check("rst_busy2 req", dmemReq, 0);
        check("rst_busy2 stall", stall, 0);
        check("rst_busy2 buserr", busErr, 0);
        check("rst_busy2 wb_we", memWbWe, 0);
        @(posedge clk); #1;
        nop();
        rstn = 1'b1;
        @(posedge clk); #1;
        check("rst_release req", dmemReq, 0);
        check("rst_release buserr", busErr, 0);
        runMem("post_reset", 32'h104, 32'h0, 1'b0, 1'b1, 5'd11, 1'b1, 32'h300, 2, 32'h1234_5678);

`ifdef MEM_TIMEOUT_EN
        aluout   = 32'h0C;
        dmemReb  = 1'b0;
        exMemRd  = 5'd2;
        regWrite = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            check($sformatf("tmo busy%0d req", c), dmemReq, 1);
            check($sformatf("tmo busy%0d buserr", c), busErr, 0);
        end
        @(posedge clk); #1;
        check("tmo done req", dmemReq, 0);
        check("tmo done stall", stall, 0);
        check("tmo done buserr", busErr, 1);
        check("tmo done wb_we", memWbWe, 0);
        nop();
        @(posedge clk); #1;
        check("tmo after buserr", busErr, 0);
        check("tmo after req", dmemReq, 0);
`else
        aluout  = 32'h0C;
        dmemReb = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            check($sformatf("nto busy%0d req", c), dmemReq, 1);
            check($sformatf("nto busy%0d buserr", c), busErr, 0);
        end
        dmemAck   = 1'b1;
        dmemRdata = 32'h7777_0000;
        @(posedge clk); #1;
        dmemAck = 1'b0;
        nop();
        check("nto done data", memWbData, 32'h7777_0000);
        @(posedge clk); #1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the number of BUSY cycles without DmemACK before abort; it is used only when MEM_TIMEOUT_EN is defined.
REQ-002 CLK  in  1  SHALL be the single clock; all state updates on posedge.
REQ-003 RSTN  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 ALUOUT  in  32  SHALL carry the EX/MEM ALU result, used as the memory address or as the writeback value.
REQ-005 WDATA  in  32  SHALL carry the EX/MEM store data.
REQ-006 PC  in  32  SHALL carry the EX/MEM program counter.
REQ-007 DmemREB, DmemWEB  in  1 each  SHALL be the EX/MEM active-low read and write enables.
REQ-008 EXMEMrd  in  5  SHALL carry the EX/MEM destination register; RegWrite  in  1  SHALL carry the EX/MEM register-write flag.
REQ-009 DmemADDR, DmemWDATA  out  32 each; DmemREQ, DmemWE  out  1 each  SHALL form the memory request bus.
REQ-010 DmemRDATA  in  32; DmemACK  in  1  SHALL form the memory response.
REQ-011 STALL  out  1  SHALL freeze the upstream pipeline (PC, IF/ID, ID/EX, EX/MEM) while high.
REQ-012 MEMWBdata, MEMWBPC  out  32; MEMWBrd  out  5; MEMWBwe  out  1  SHALL be the registered MEM/WB outputs.
REQ-013 MISALIGN, BUSERR  out  1 each  SHALL be one-cycle error pulses.

Function
REQ-014 The FSM SHALL have the states IDLE, BUSY and DONE.
REQ-015 IDLE with both enables high: MEMWB* SHALL load ALUOUT, PC, EXMEMrd and RegWrite on the next edge, with 1-cycle latency and no stall.
REQ-016 IDLE with either enable low and ALUOUT[1:0]==0: the block SHALL latch address, data, rd and we, go to BUSY, and drive STALL high combinationally in that same cycle.
REQ-017 If DmemWEB and DmemREB are both low, the write SHALL take priority and no read SHALL be issued.
REQ-018 Misaligned access (ALUOUT[1:0]!=0) SHALL issue no request and pulse MISALIGN for one cycle; MEMWBwe SHALL be 0 for that instruction, with no stall.
REQ-019 BUSY: DmemREQ SHALL be 1 and DmemADDR, DmemWDATA and DmemWE SHALL be held stable from the latched values; STALL SHALL be 1.
REQ-020 BUSY on DmemACK: a read SHALL capture DmemRDATA into MEMWBdata; a write SHALL set MEMWBwe to 0; the FSM SHALL go to DONE, with DmemREQ low from the next cycle.
REQ-021 DONE: STALL SHALL be 0, MEMWB* SHALL hold the completed result, and the FSM SHALL return to IDLE after one cycle; a new access is accepted on the following cycle.
REQ-022 DmemACK outside BUSY SHALL be ignored.
REQ-023 Memory-op latency SHALL be (cycles to ACK) + 1 edges from the IDLE sample to a valid MEMWBdata.

Reset
REQ-024 While RSTN is low, the state SHALL be IDLE, and all outputs and MEMWB* SHALL be 0, including STALL and DmemREQ.
REQ-025 Reset asserted during BUSY SHALL drop DmemREQ immediately (asynchronously), discard the access, and issue no BUSERR.

Configuration
REQ-026 With MEM_TIMEOUT_EN defined, an 8-bit counter SHALL run in BUSY; reaching TIMEOUT_CYCLES without ACK SHALL drop DmemREQ, pulse BUSERR, force MEMWBwe to 0, and go to DONE.
REQ-027 With MEM_TIMEOUT_EN undefined, the counter SHALL be absent, BUSY SHALL wait indefinitely, and BUSERR SHALL be tied to 0.

Structure
REQ-028 The state encoding enum (IDLE, BUSY, DONE) and the width constants (XLEN=32, REGW=5) SHALL live in the shared pipeline package.
REQ-029 The timeout counter SHALL be a sub-module named mem_timeout_ctr, instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-030 ALU op with enables high, ALUOUT=0x0000_1234 and rd=7 -> MEMWBdata=0x1234 and MEMWBrd=7 after 1 edge, with STALL always 0.
REQ-031 Load at 0x100 with ACK after 3 cycles and RDATA=0xDEADBEEF -> STALL high for 4 cycles, then MEMWBdata=0xDEADBEEF.
REQ-032 Store with WDATA=0xA5A5A5A5 and both enables low -> DmemWE=1 and DmemWDATA=0xA5A5A5A5 held until ACK, then MEMWBwe=0.
REQ-033 Load at 0x102 -> MISALIGN pulse, DmemREQ never 1, MEMWBwe=0.
REQ-034 RSTN low in the 2nd BUSY cycle -> DmemREQ=0 and STALL=0 the same cycle; the next access proceeds normally.
REQ-035 With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, a load with no ACK -> BUSERR pulse after 4 BUSY cycles and DmemREQ=0 afterwards.
